// File: rtl/heai_pkg.sv
// heai_pkg: shared state encoding, config addresses and reset values for the NCO sweep controller.
package heai_pkg;
    typedef enum logic [1:0] {IDLE, SETTLE, DWELL} state_t;
    localparam logic [1:0] CFG_INC = 2'd0, CFG_STEP = 2'd1, CFG_NSTEPS = 2'd2, CFG_DWELL = 2'd3;
    localparam logic [7:0] RST_START_INC = 8'd3, RST_RF_INC = 8'd2, RST_STEP_INC = 8'd1, RST_NUM_STEPS = 8'd0;
    localparam logic [15:0] RST_DWELL = 16'd1;
    localparam logic [5:0] DAC_MID = 6'd32;
endpackage

// File: rtl/nco_sweep_ctrl_cycle_timer.sv
// cycle_timer: loadable down-counter; expired is high while the count sits at zero.
module cycle_timer #(
    parameter int W = 16
) (
    input  logic         pll_clock,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] value,
    output logic         expired
);
    logic [W-1:0] count;
    always_ff @(posedge pll_clock)
        if (!rst_n) count <= '0;
        else count <= load ? value : (en && count != '0) ? count - W'(1) : count;
    assign expired = count == '0;
endmodule

// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl: steps the LO phase increment through a linear sweep with settle/dwell timing.
// Define NCO_SWEEP_LOOP_EN to restart the sweep endlessly until stop or reset.
import heai_pkg::*;
module nco_sweep_ctrl #(
    parameter int PHASE_W       = 8,
    parameter int DWELL_W       = 16,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic               pll_clock,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_addr,
    input  logic [15:0]        cfg_wdata,
    input  logic               start,
    input  logic               stop,
    output logic [PHASE_W-1:0] lo_inc,
    output logic [PHASE_W-1:0] rf_inc,
    output logic               clk_en,
    output logic               mute,
    output logic               busy,
    output logic               step_done,
    output logic               sweep_done
);
`ifdef NCO_SWEEP_LOOP_EN
    localparam logic LOOP = 1'b1;
`else
    localparam logic LOOP = 1'b0;
`endif
    state_t state, state_nx;
    logic [PHASE_W-1:0] cfg_start, cfg_rf, cfg_step, act_start, act_step;
    logic [7:0] cfg_nsteps, act_nsteps, cnt;
    logic [DWELL_W-1:0] cfg_dwell, act_dwell, dwell_m1, timer_val;
    logic expired, last, fin;
    always_ff @(posedge pll_clock)
        if (!rst_n) begin
            cfg_start  <= PHASE_W'(RST_START_INC);
            cfg_rf     <= PHASE_W'(RST_RF_INC);
            cfg_step   <= PHASE_W'(RST_STEP_INC);
            cfg_nsteps <= RST_NUM_STEPS;
            cfg_dwell  <= DWELL_W'(RST_DWELL);
        end else if (cfg_we) begin
            if (cfg_addr == CFG_INC) begin
                cfg_start <= cfg_wdata[PHASE_W-1:0];
                cfg_rf    <= cfg_wdata[8 +: PHASE_W];
            end
            if (cfg_addr == CFG_STEP) cfg_step <= cfg_wdata[PHASE_W-1:0];
            if (cfg_addr == CFG_NSTEPS) cfg_nsteps <= cfg_wdata[7:0];
            if (cfg_addr == CFG_DWELL) cfg_dwell <= cfg_wdata[DWELL_W-1:0];
        end
    always_ff @(posedge pll_clock)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    assign last = cnt == 8'd0;
    assign fin  = state == DWELL && expired && !stop && rst_n;
    always_comb begin
        state_nx = stop ? IDLE :
                   state == IDLE ? (start ? SETTLE : IDLE) :
                   state == SETTLE ? (expired ? DWELL : SETTLE) :
                   !expired ? DWELL : (last && !LOOP) ? IDLE : SETTLE;
    end
    always_comb begin
        clk_en     = state != IDLE;
        busy       = state != IDLE;
        mute       = state != DWELL;
        step_done  = fin;
        sweep_done = fin && last;
    end
    // Active sweep values are snapshotted at start so config writes only affect the next sweep.
    always_ff @(posedge pll_clock)
        if (!rst_n) begin
            lo_inc     <= PHASE_W'(RST_START_INC);
            rf_inc     <= PHASE_W'(RST_RF_INC);
            cnt        <= '0;
            act_start  <= PHASE_W'(RST_START_INC);
            act_step   <= PHASE_W'(RST_STEP_INC);
            act_nsteps <= RST_NUM_STEPS;
            act_dwell  <= DWELL_W'(RST_DWELL);
        end else if (state == IDLE && start && !stop) begin
            lo_inc     <= cfg_start;
            rf_inc     <= cfg_rf;
            cnt        <= cfg_nsteps;
            act_start  <= cfg_start;
            act_step   <= cfg_step;
            act_nsteps <= cfg_nsteps;
            act_dwell  <= cfg_dwell;
        end else if (fin) begin
            if (!last) begin
                cnt    <= cnt - 8'd1;
                lo_inc <= lo_inc + act_step;
            end else if (LOOP) begin
                cnt    <= act_nsteps;
                lo_inc <= act_start;
            end
        end
    // One timer serves both intervals; it reloads on every state change.
    assign dwell_m1  = act_dwell == '0 ? '0 : act_dwell - DWELL_W'(1);
    assign timer_val = state_nx == SETTLE ? DWELL_W'(SETTLE_CYCLES - 1) : dwell_m1;
    cycle_timer #(.W(DWELL_W)) timer (
        .pll_clock (pll_clock),
        .rst_n     (rst_n),
        .load      (state_nx != state),
        .en        (state != IDLE),
        .value     (timer_val),
        .expired   (expired)
    );
endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// tb_nco_sweep_ctrl: directed checks of reset, sweeps, wrap, abort, config snapshot and edge values.
module tb_nco_sweep_ctrl;
    logic pll_clock = 0, rst_n = 0, cfg_we = 0, start = 0, stop = 0;
    logic [1:0] cfg_addr = 0;
    logic [15:0] cfg_wdata = 0;
    logic [7:0] lo_inc, rf_inc;
    logic clk_en, mute, busy, step_done, sweep_done;
    int checks = 0, failures = 0;

    nco_sweep_ctrl dut (
        .pll_clock(pll_clock), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .start(start), .stop(stop), .lo_inc(lo_inc), .rf_inc(rf_inc),
        .clk_en(clk_en), .mute(mute), .busy(busy), .step_done(step_done), .sweep_done(sweep_done)
    );

    always #5 pll_clock = ~pll_clock;

    task automatic tick();
        @(posedge pll_clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic cfg(input logic [1:0] a, input logic [15:0] d);
        cfg_we = 1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_we = 0;
    endtask

    task automatic pulse_start();
        start = 1;
        tick();
        start = 0;
    endtask

    // Settle is 4 cycles, then dw dwell cycles per step; lo steps by st modulo 256.
    task automatic sweep_check(input string tag, input int steps, input int dw,
                               input logic [7:0] l0, input logic [7:0] st);
        int per, w, s;
        logic [7:0] e;
        per = 4 + dw;
        pulse_start();
        for (int k = 1; k <= steps * per; k++) begin
            w = (k - 1) % per;
            s = (k - 1) / per;
            e = 8'(int'(l0) + int'(st) * s);
            chk({tag, "_mute"}, mute, w < 4);
            chk({tag, "_lo"}, lo_inc, e);
            chk({tag, "_busy"}, busy, 1);
            chk({tag, "_step"}, step_done, w == per - 1);
            chk({tag, "_sweep"}, sweep_done, k == steps * per);
            tick();
        end
        chk({tag, "_end_busy"}, busy, 0);
        chk({tag, "_end_clken"}, clk_en, 0);
        chk({tag, "_end_mute"}, mute, 1);
    endtask

    initial begin
        int n;
        repeat (3) tick();
        chk("rst_lo", lo_inc, 3);
        chk("rst_rf", rf_inc, 2);
        chk("rst_clken", clk_en, 0);
        chk("rst_mute", mute, 1);
        chk("rst_busy", busy, 0);
        chk("rst_pulses", {step_done, sweep_done}, 0);
        rst_n = 1;
        tick();
        sweep_check("rstcfg", 1, 1, 8'd3, 8'd1);

        cfg(0, 16'h140A); cfg(1, 16'd5); cfg(2, 16'd2); cfg(3, 16'd8);
        sweep_check("basic", 3, 8, 8'd10, 8'd5);
        chk("basic_rf", rf_inc, 20);

        cfg(0, {8'd20, 8'd250}); cfg(1, 16'd10); cfg(2, 16'd1); cfg(3, 16'd2);
        sweep_check("wrap", 2, 2, 8'd250, 8'd10);
        cfg(0, {8'd20, 8'd2}); cfg(1, 16'h00FB);
        sweep_check("neg", 2, 2, 8'd2, 8'hFB);

        cfg(0, 16'h140A); cfg(1, 16'd5); cfg(2, 16'd2); cfg(3, 16'd8);
        pulse_start();
        repeat (16) tick();
        chk("abort_pre_mute", mute, 0);
        chk("abort_pre_lo", lo_inc, 15);
        stop = 1;
        chk("abort_sweep", sweep_done, 0);
        tick();
        stop = 0;
        chk("abort_busy", busy, 0);
        chk("abort_clken", clk_en, 0);
        chk("abort_mute", mute, 1);
        chk("abort_lo", lo_inc, 15);
        start = 1; stop = 1;
        tick();
        start = 0; stop = 0;
        chk("ss_busy", busy, 0);
        tick();
        chk("ss_busy2", busy, 0);

        pulse_start();
        cfg(0, {8'd20, 8'd99});
        pulse_start();
        chk("mid_lo", lo_inc, 10);
        tick();
        chk("mid_lo_k4", lo_inc, 10);
        repeat (13) tick();
        chk("mid_lo_k17", lo_inc, 15);
        chk("mid_mute_k17", mute, 0);
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        chk("mid_done_bound", busy, 0);
        pulse_start();
        chk("mid_next_lo", lo_inc, 99);
        repeat (6) tick();
        rst_n = 0;
        chk("rst_mid_pulses", {step_done, sweep_done}, 0);
        tick();
        chk("rst_mid_lo", lo_inc, 3);
        chk("rst_mid_rf", rf_inc, 2);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_mute", mute, 1);
        rst_n = 1;
        tick();

        cfg(0, {8'd20, 8'd40}); cfg(2, 16'd0); cfg(3, 16'd0);
        sweep_check("edge", 1, 1, 8'd40, 8'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
